// File: rtl/mem_stage_ram.sv
// Purpose : MEM-stage data memory fed by EX_MEM. After reset it writes
//           INIT_VALUE to every word, then serves single-cycle reads and
//           writes. Out-of-range and read+write requests are rejected and
//           counted in a saturating counter.
// Latency : read data and its valid pulse appear 1 rising edge after the request.
// Backpressure: none. mem_ready is low for the DEPTH-cycle init sweep, and
//           requests made during the sweep are dropped. In RUN every cycle
//           accepts a request.
// Ports   : clk/rst (async, active-high); mem_read_ctrl, mem_write_ctrl,
//           mem_address and mem_data_write (request); mem_data_read and
//           mem_read_valid (read response); mem_ready; mem_addr_err and
//           mem_err_count (reject pulse and saturating reject count).
module mem_stage_ram #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 6,
    parameter int                DEPTH      = 40,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int                ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_ctrl,
    input  logic              mem_write_ctrl,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_write,
    output logic [DATA_W-1:0] mem_data_read,
    output logic              mem_read_valid,
    output logic              mem_ready,
    output logic              mem_addr_err,
    output logic [ERR_W-1:0]  mem_err_count
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
    // One extra bit so DEPTH itself fits, even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]   ram_q [DEPTH];

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                addr_ok;

    // Codes DEPTH..2**ADDR_W-1 are rejected, not aliased onto real words.
    assign addr_ok = ({1'b0, mem_address} < DEPTH_A);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;

        case (state_q)
            S_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = ADDR_W'(cnt_q);
                ram_wdata = INIT_VALUE;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (mem_read_ctrl || mem_write_ctrl) begin
                    if ((mem_read_ctrl && mem_write_ctrl) || !addr_ok) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end else if (mem_read_ctrl) begin
                        data_d = ram_q[mem_address];
                        vld_d  = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = mem_address;
                        ram_wdata = mem_data_write;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // The storage has no reset, so a RAM can be inferred. The write is gated
    // while rst is high: reset leaves the contents alone, and the sweep clears them.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    assign mem_data_read  = data_q;
    assign mem_read_valid = vld_q;
    assign mem_ready      = (state_q == S_RUN);
    assign mem_addr_err   = err_q;
    assign mem_err_count  = err_cnt_q;

endmodule

// File: tb/tb_mem_stage_ram.sv
module tb_mem_stage_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd = 1'b0, wr = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] wdat = '0;
    logic [7:0] rdat;
    logic       rvld, rdy, aerr;
    logic [7:0] ecnt;

    // Second instance with a 2-bit error counter, used for the saturation check.
    logic       rd2 = 1'b0, wr2 = 1'b0;
    logic [5:0] addr2 = '0;
    logic [7:0] wdat2 = '0;
    logic [7:0] rdat2;
    logic       rvld2, rdy2, aerr2;
    logic [1:0] ecnt2;

    mem_stage_ram dut (
        .clk(clk), .rst(rst),
        .mem_read_ctrl(rd), .mem_write_ctrl(wr),
        .mem_address(addr), .mem_data_write(wdat),
        .mem_data_read(rdat), .mem_read_valid(rvld),
        .mem_ready(rdy), .mem_addr_err(aerr), .mem_err_count(ecnt)
    );

    mem_stage_ram #(.ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .mem_read_ctrl(rd2), .mem_write_ctrl(wr2),
        .mem_address(addr2), .mem_data_write(wdat2),
        .mem_data_read(rdat2), .mem_read_valid(rvld2),
        .mem_ready(rdy2), .mem_addr_err(aerr2), .mem_err_count(ecnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_mem [64];
    int         exp_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops one expectation per response pulse, independent of the driver.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_err_exclusive", {31'b0, rvld & aerr}, 0);
            if (rvld || aerr) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, rvld, aerr}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.is_err) begin
                        check("err_pulse", {30'b0, rvld, aerr}, 1);
                        check("err_count", {24'b0, ecnt}, {24'b0, e.val});
                    end else begin
                        check("read_pulse", {30'b0, rvld, aerr}, 2);
                        check("read_data", {24'b0, rdat}, {24'b0, e.val});
                    end
                end
            end
        end
    end

    // Drives one request at the falling edge and updates the reference model.
    task automatic issue(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdat = d;
        if (r || w) begin
            if ((r && w) || a >= 6'd40) begin
                if (exp_cnt < 255) exp_cnt++;
                e.is_err = 1'b1; e.val = 8'(exp_cnt);
                sb_q.push_back(e);
            end else if (r) begin
                e.is_err = 1'b0; e.val = exp_mem[a];
                sb_q.push_back(e);
            end else begin
                exp_mem[a] = d;
            end
        end
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 6'd0, 8'd0);
    endtask

    // Counts rising edges from the current point until mem_ready is seen high.
    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!rdy && n < 100);
        check(name, n, 40);
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_cnt = 0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'b0, rdat}, 0);
        check({tag, "_valid"}, {31'b0, rvld}, 0);
        check({tag, "_ready"}, {31'b0, rdy},  0);
        check({tag, "_err"},   {31'b0, aerr}, 0);
        check({tag, "_count"}, {24'b0, ecnt}, 0);
    endtask

    // Asserts rst a few ns after a falling edge, i.e. away from any rising edge.
    task automatic async_reset_pulse(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");

        // A write is held throughout the sweep. It must be ignored.
        @(negedge clk);
        wr = 1'b1; addr = 6'd17; wdat = 8'h77;
        rst = 1'b0;
        wait_ready("init_cycles");
        wr = 1'b0; addr = '0; wdat = '0;

        issue(1, 0, 6'd0,  8'h00);
        issue(1, 0, 6'd17, 8'h00);
        issue(1, 0, 6'd39, 8'h00);
        idle();

        issue(0, 1, 6'd12, 8'hA5);
        issue(1, 0, 6'd12, 8'h00);
        idle();
        idle();
        check("read_hold_data",  {24'b0, rdat}, 32'hA5);
        check("read_hold_valid", {31'b0, rvld}, 0);

        issue(0, 1, 6'd39, 8'h5A);
        issue(0, 1, 6'd40, 8'hEE);
        issue(1, 0, 6'd63, 8'h00);
        issue(1, 0, 6'd39, 8'h00);
        idle();
        check("boundary_count", {24'b0, ecnt}, 2);

        issue(1, 1, 6'd5, 8'h3C);
        issue(1, 0, 6'd5, 8'h00);
        idle();
        check("conflict_count", {24'b0, ecnt}, 3);

        // Saturation on the 2-bit instance: five rejected reads at address 50.
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i > 1) check("sat_count", {30'b0, ecnt2}, (i - 1 > 3) ? 3 : i - 1);
            rd2 = (i <= 5); addr2 = 6'd50;
        end
        @(negedge clk);
        check("sat_hold", {30'b0, ecnt2}, 3);
        check("sat_main_untouched", {24'b0, ecnt}, 3);

        // Reset during RUN must clear the outputs and re-run the full sweep.
        issue(0, 1, 6'd3, 8'hFF);
        issue(1, 0, 6'd3, 8'h00);
        idle();
        async_reset_pulse("run_reset");
        wait_ready("run_reset_cycles");

        // Re-reset partway through the sweep restarts it from address 0.
        async_reset_pulse("pre_sweep_reset");
        repeat (20) @(posedge clk);
        #1 check("mid_sweep_ready", {31'b0, rdy}, 0);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_ready("resweep_cycles");
        issue(1, 0, 6'd3, 8'h00);
        issue(1, 0, 6'd12, 8'h00);
        idle();
        idle();
        check("final_count", {24'b0, ecnt}, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ram.md
Name: mem_stage_ram

Overview:
Parametrised data memory for the MEM pipeline stage, driven by the EX_MEM pipeline register. It replaces the fixed 3-bit by 40-entry memory. The block:
- runs on the rising edge and has an asynchronous reset;
- clears its own contents after reset with a hardware init sweep;
- reports read completion with a valid pulse;
- flags out-of-range and conflicting accesses, and counts them.

Parameters:
DATA_W, 8, width of each memory word and of the data ports.
ADDR_W, 6, width of mem_address; must satisfy 2**ADDR_W >= DEPTH.
DEPTH, 40, number of words; need not be a power of two.
INIT_VALUE, 0, value written to every word during the init sweep.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
mem_read_ctrl  input  1  read request from EX_MEM.
mem_write_ctrl  input  1  write request from EX_MEM.
mem_address  input  ADDR_W  word address.
mem_data_write  input  DATA_W  write data.
mem_data_read  output  DATA_W  registered read data.
mem_read_valid  output  1  one-cycle pulse: mem_data_read was updated this cycle.
mem_ready  output  1  high when the block accepts requests (RUN state).
mem_addr_err  output  1  one-cycle pulse: the request was rejected.
mem_err_count  output  ERR_W  count of rejected requests; saturates.

Behaviour:
- Reset (rst=1, asynchronous):
  - mem_data_read=0, mem_read_valid=0, mem_ready=0, mem_addr_err=0, mem_err_count=0.
  - State goes to INIT and the sweep counter goes to 0.
  - Array contents are not touched by reset itself.
- INIT state:
  - Each cycle: array[counter] <= INIT_VALUE, then counter increments.
  - After the write at counter=DEPTH-1, the next state is RUN; mem_ready rises on that same edge.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - All requests during INIT are ignored: no write, no valid, no error, no count change.
- RUN state; a request is evaluated at each rising edge:
  - Read only (read=1, write=0, address < DEPTH): mem_data_read <= array[address] and mem_read_valid=1 for that one cycle. Read latency is 1 edge.
  - Write only (read=0, write=1, address < DEPTH): array[address] <= mem_data_write. No output change besides the pulses going low.
  - Neither asserted: idle. All pulses are 0.
  - Both asserted: conflict. No array access, mem_addr_err=1 for one cycle, counter increments.
  - Either asserted with address >= DEPTH: no array access, mem_addr_err=1, counter increments, mem_read_valid=0.
- mem_data_read holds its last value whenever mem_read_valid=0.
- mem_read_valid and mem_addr_err are never high in the same cycle.
- mem_err_count increments by 1 per rejected request and saturates at 2**ERR_W-1. It never wraps.
- Back-to-back accesses:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data. No forwarding path is needed, because reads and writes never occur in the same cycle.
  - Requests are accepted on every consecutive cycle with no bubbles.
- Reset mid-INIT restarts the sweep at 0. Reset during RUN returns to INIT and re-clears the full array.
- Address width: unused upper address codes (DEPTH to 2**ADDR_W-1) are the error range. No aliasing is allowed.
- The array is synthesised as plain registers or inferred RAM. Its only write sources are the sweep and write-only RUN requests.

Test Plan:
- Init sweep: deassert rst, then read addr 0, 17 and 39 once mem_ready=1. Required: mem_ready rises exactly 40 cycles after rst falls; all three reads return 0 with mem_read_valid pulsing once each.
- Write/read: write 0xA5 to addr 12, then read addr 12 on the next cycle. Required: mem_data_read=0xA5 one edge later, mem_read_valid high for exactly 1 cycle, and mem_data_read holds 0xA5 afterwards.
- Boundary and error:
  - Write to addr 39: required to succeed.
  - Write to addr 40 and read addr 63: required to give mem_addr_err pulses, mem_err_count=2, and no array change (addr 39 still correct).
- Conflict: assert read and write together at addr 5 with data 0x3C. Required: mem_addr_err=1, mem_read_valid=0, addr 5 unchanged (0 after init), count +1.
- Saturation: with ERR_W=2, issue 5 rejected requests. Required: mem_err_count=3 and it stays at 3.
- Reset mid-operation:
  - Write 0xFF to addr 3, then pulse rst asynchronously between edges. Required: outputs go to 0 immediately and mem_ready=0 for 40 cycles.
  - Re-reset during the sweep (cycle 20). Required: the sweep restarts and addr 3 reads 0 after the final ready.
